// File: rtl/reg_writeback.sv
// reg_writeback: the only writer of the 32x32 register file write port.
// It merges ALU results and returning load data onto one registered write
// port. ALU results that lose arbitration wait in a one-entry skid buffer.
// Sub-word loads are sign- or zero-extended. Registers that still have a
// write in flight are reported to decode as a hazard so decode can stall.
`timescale 1ns/1ps

module reg_writeback #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              load_issue,
    output logic              load_ready,
    input  logic [REG_AW-1:0] load_dest,
    input  logic [2:0]        load_type,
    input  logic [1:0]        load_offset,
    input  logic              mem_readdatavalid,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic [REG_AW-1:0] chk_reg,
    output logic              chk_hazard,
    output logic              load_pending,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData
);

    // Load-type encodings as they arrive on load_type.
    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;

    typedef enum logic {
        ST_IDLE,
        ST_LOAD_PEND
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Attributes of the outstanding load. They are captured at issue, so later
    // changes on the load_* inputs have no effect on the load in flight.
    logic [REG_AW-1:0] r_pend_dest;
    logic [2:0]        r_pend_type;
    logic [1:0]        r_pend_offset;

    // One-entry skid buffer for an ALU result that lost arbitration.
    logic              r_buf_full;
    logic [REG_AW-1:0] r_buf_dest;
    logic [DATA_W-1:0] r_buf_data;

    // Handshake qualifiers.
    logic w_load_acc;   // load accepted this cycle
    logic w_load_ret;   // load data returns this cycle, in LOAD_PEND only
    logic w_alu_acc;    // ALU result accepted this cycle

    // Arbitration winner for the write port.
    logic              w_win_valid;
    logic [REG_AW-1:0] w_win_dest;
    logic [DATA_W-1:0] w_win_data;

    // Extracted lanes and the extended load value.
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [DATA_W-1:0] w_load_value;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register. A reset that arrives mid-load discards the load.
    // NOTE: sequential state is assigned with <= so that every flop samples
    // values from before the clock edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A load is accepted only in IDLE. The return is
    // recognised only in LOAD_PEND.
    // NOTE: every signal written in always_comb gets a default first. Any path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (load_issue)        w_state_next = ST_LOAD_PEND;
            ST_LOAD_PEND: if (mem_readdatavalid) w_state_next = ST_IDLE;
            default:                             w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs and load handshake qualifiers.
    always_comb begin
        load_ready   = 1'b0;
        load_pending = 1'b0;
        w_load_acc   = 1'b0;
        w_load_ret   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
                w_load_acc = load_issue;
            end
            ST_LOAD_PEND: begin
                load_pending = 1'b1;
                w_load_ret   = mem_readdatavalid;
            end
            default: begin
                load_ready = 1'b1;
            end
        endcase
    end

    // Capture the load attributes when the load is accepted.
    // NOTE: these registers are reset so that WriteData and chk_hazard are
    // deterministic from the first cycle. The data value does not depend on
    // the reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_dest   <= '0;
            r_pend_type   <= '0;
            r_pend_offset <= '0;
        end else if (w_load_acc) begin
            r_pend_dest   <= load_dest;
            r_pend_type   <= load_type;
            r_pend_offset <= load_offset;
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction and extension
    // ------------------------------------------------------------------

    // Select the addressed byte and halfword lanes of the returned word.
    always_comb begin
        w_lane_byte = mem_readdata[7:0];
        unique case (r_pend_offset)
            2'd0: w_lane_byte = mem_readdata[7:0];
            2'd1: w_lane_byte = mem_readdata[15:8];
            2'd2: w_lane_byte = mem_readdata[23:16];
            2'd3: w_lane_byte = mem_readdata[31:24];
            default: w_lane_byte = mem_readdata[7:0];
        endcase
        w_lane_half = r_pend_offset[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    end

    // Extend the selected lane. Unused type codes behave as LW.
    always_comb begin
        w_load_value = mem_readdata;
        unique case (r_pend_type)
            LT_LB:   w_load_value = {{(DATA_W-8){w_lane_byte[7]}}, w_lane_byte};
            LT_LBU:  w_load_value = {{(DATA_W-8){1'b0}}, w_lane_byte};
            LT_LH:   w_load_value = {{(DATA_W-16){w_lane_half[15]}}, w_lane_half};
            LT_LHU:  w_load_value = {{(DATA_W-16){1'b0}}, w_lane_half};
            default: w_load_value = mem_readdata;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU skid buffer and write-port arbitration
    // ------------------------------------------------------------------

    assign alu_ready = !r_buf_full;
    assign w_alu_acc = alu_valid && !r_buf_full;

    // Pick at most one writer per cycle. Priority is: load return, then the
    // buffered ALU entry, then the ALU result accepted this cycle. While the
    // buffer is full no new ALU result can be accepted, so ALU order holds.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_dest  = '0;
        w_win_data  = '0;
        if (w_load_ret) begin
            w_win_valid = 1'b1;
            w_win_dest  = r_pend_dest;
            w_win_data  = w_load_value;
        end else if (r_buf_full) begin
            w_win_valid = 1'b1;
            w_win_dest  = r_buf_dest;
            w_win_data  = r_buf_data;
        end else if (w_alu_acc) begin
            w_win_valid = 1'b1;
            w_win_dest  = alu_dest;
            w_win_data  = alu_data;
        end
    end

    // Fill the buffer when an accepted ALU result loses to a load return.
    // Drain the buffer in the first cycle with no load return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf_full <= 1'b0;
            r_buf_dest <= '0;
            r_buf_data <= '0;
        end else if (w_load_ret && w_alu_acc) begin
            r_buf_full <= 1'b1;
            r_buf_dest <= alu_dest;
            r_buf_data <= alu_data;
        end else if (!w_load_ret && r_buf_full) begin
            r_buf_full <= 1'b0;
        end
    end

    // Register the winner onto the write port. A write to register 0 keeps
    // its slot but never raises RegWrite.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= w_win_valid && (w_win_dest != '0);
            if (w_win_valid) begin
                WriteReg  <= w_win_dest;
                WriteData <= w_win_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-after-write hazard report
    // ------------------------------------------------------------------

    // Flag chk_reg while a load or a buffered ALU result still targets it.
    // The flag clears in the cycle the write reaches the write port.
    always_comb begin
        chk_hazard = 1'b0;
        if (load_pending && (chk_reg == r_pend_dest) && (r_pend_dest != '0))
            chk_hazard = 1'b1;
        if (r_buf_full && (chk_reg == r_buf_dest) && (r_buf_dest != '0))
            chk_hazard = 1'b1;
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback. Stimulus advances a transaction-level model:
// accepted ALU results sit in a FIFO, one load can be outstanding, and each
// cycle at most one write goes out. A load return goes first, otherwise the
// oldest ALU result goes. Each expected write is queued with the cycle it
// should appear in. A separate monitor pops the queue and compares it with
// the register-file write port.
`timescale 1ns/1ps

module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_dest = '0;
    logic [31:0] alu_data = '0;
    logic        load_issue = 1'b0;
    logic        load_ready;
    logic [4:0]  load_dest = '0;
    logic [2:0]  load_type = '0;
    logic [1:0]  load_offset = '0;
    logic        mem_readdatavalid = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic [4:0]  chk_reg = '0;
    logic        chk_hazard;
    logic        load_pending;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk               (clk),
        .reset             (reset),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_dest          (alu_dest),
        .alu_data          (alu_data),
        .load_issue        (load_issue),
        .load_ready        (load_ready),
        .load_dest         (load_dest),
        .load_type         (load_type),
        .load_offset       (load_offset),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .chk_reg           (chk_reg),
        .chk_hazard        (chk_hazard),
        .load_pending      (load_pending),
        .RegWrite          (RegWrite),
        .WriteReg          (WriteReg),
        .WriteData         (WriteData)
    );

    typedef struct {
        bit          rst_n;
        bit          av;
        logic [4:0]  ad;
        logic [31:0] adat;
        bit          li;
        logic [4:0]  ld;
        logic [2:0]  lt;
        logic [1:0]  lo;
        bit          mv;
        logic [31:0] md;
        logic [4:0]  ck;
    } stim_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } alu_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    // Scoreboard and reference-model state.
    wr_t         exp_q[$];
    alu_t        m_alu_q[$];
    bit          m_pend = 1'b0;
    logic [4:0]  m_pdest = '0;
    logic [2:0]  m_ptype = '0;
    logic [1:0]  m_poff = '0;
    bit          m_acc_a;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Value a load writes back, computed directly from the extension rules.
    function automatic logic [31:0] load_value(input logic [31:0] raw, input logic [2:0] t,
                                               input logic [1:0] o);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(raw >> (8 * o));
        h = 16'(raw >> (16 * o[1]));
        case (t)
            3'd0:    r = 32'($signed(b));
            3'd1:    r = {24'b0, b};
            3'd2:    r = 32'($signed(h));
            3'd3:    r = {16'b0, h};
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{rst_n: 1'b1, av: 1'b0, ad: '0, adat: '0, li: 1'b0, ld: '0, lt: '0,
              lo: '0, mv: 1'b0, md: '0, ck: '0};
        return s;
    endfunction

    // Apply one cycle of stimulus. Check the combinational outputs against
    // the model, then advance the model across the next clock edge.
    task automatic step(input stim_t s);
        bit   ret;
        bit   acc_l;
        bit   have_w;
        bit   exp_haz;
        alu_t w;
        @(posedge clk);
        #1;
        reset             = s.rst_n;
        alu_valid         = s.av;
        alu_dest          = s.ad;
        alu_data          = s.adat;
        load_issue        = s.li;
        load_dest         = s.ld;
        load_type         = s.lt;
        load_offset       = s.lo;
        mem_readdatavalid = s.mv;
        mem_readdata      = s.md;
        chk_reg           = s.ck;
        @(negedge clk);
        m_acc_a = 1'b0;
        if (!s.rst_n) begin
            m_alu_q.delete();
            m_pend = 1'b0;
            check("rst_RegWrite", 32'(RegWrite), 32'd0);
            check("rst_WriteReg", 32'(WriteReg), 32'd0);
            check("rst_WriteData", WriteData, 32'd0);
            check("rst_alu_ready", 32'(alu_ready), 32'd1);
            check("rst_load_ready", 32'(load_ready), 32'd1);
            check("rst_load_pending", 32'(load_pending), 32'd0);
            check("rst_chk_hazard", 32'(chk_hazard), 32'd0);
            return;
        end
        exp_haz = (m_pend && s.ck == m_pdest && m_pdest != 0) ||
                  (m_alu_q.size() > 0 && s.ck == m_alu_q[0].dest && m_alu_q[0].dest != 0);
        check("alu_ready", 32'(alu_ready), 32'(m_alu_q.size() == 0));
        check("load_ready", 32'(load_ready), 32'(!m_pend));
        check("load_pending", 32'(load_pending), 32'(m_pend));
        check("chk_hazard", 32'(chk_hazard), 32'(exp_haz));

        ret     = m_pend && s.mv;
        m_acc_a = s.av && (m_alu_q.size() == 0);
        acc_l   = s.li && !m_pend;
        have_w  = 1'b0;
        if (ret) begin
            w.dest = m_pdest;
            w.data = ovr_en ? ovr_data : load_value(s.md, m_ptype, m_poff);
            have_w = 1'b1;
            m_pend = 1'b0;
        end
        if (m_acc_a) m_alu_q.push_back('{s.ad, s.adat});
        if (!have_w && m_alu_q.size() > 0) begin
            w = m_alu_q.pop_front();
            have_w = 1'b1;
        end
        if (acc_l) begin
            m_pend  = 1'b1;
            m_pdest = s.ld;
            m_ptype = s.lt;
            m_poff  = s.lo;
        end
        if (have_w && w.dest != 0) exp_q.push_back('{w.dest, w.data, cyc + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(idle_stim());
    endtask

    // Monitor: each cycle, match the write port against the scoreboard.
    wr_t e;
    always @(negedge clk) begin
        if (reset) begin
            if (RegWrite) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write @cyc %0d: got WriteReg=%0d WriteData=0x%08h expected no write",
                             cyc, WriteReg, WriteData);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", 32'(cyc), 32'(e.cyc));
                    check("WriteReg", 32'(WriteReg), 32'(e.dest));
                    check("WriteData", WriteData, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_write @cyc %0d: got RegWrite=0 expected WriteReg=%0d WriteData=0x%08h",
                         cyc, e.dest, e.data);
            end
        end
    end

    stim_t s;
    logic [2:0]  lt_tab[5]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0]  lo_tab[5]  = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
    logic [31:0] exp_tab[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280,
                                32'h0000_3456, 32'h1280_3456};

    initial begin
        // Reset state.
        s = idle_stim();
        s.rst_n = 1'b0;
        step(s);
        step(s);
        idle(2);

        // Single ALU write, then a write to register 0.
        s = idle_stim(); s.av = 1; s.ad = 5'd8; s.adat = 32'hDEAD_BEEF; step(s);
        idle(2);
        s = idle_stim(); s.av = 1; s.ad = 5'd0; s.adat = 32'h0000_1234; step(s);
        idle(2);

        // Load extension against fixed expected values.
        for (int i = 0; i < 5; i++) begin
            s = idle_stim(); s.li = 1; s.ld = 5'd7; s.lt = lt_tab[i]; s.lo = lo_tab[i]; s.ck = 5'd7;
            step(s);
            s = idle_stim(); s.li = 1; s.ld = 5'd12; s.lt = 3'd1; s.lo = 2'd3; s.ck = 5'd7;
            step(s);
            ovr_en = 1'b1;
            ovr_data = exp_tab[i];
            s = idle_stim(); s.mv = 1; s.md = 32'h1280_3456; s.ck = 5'd7;
            step(s);
            ovr_en = 1'b0;
            idle(1);
        end

        // A load return and an ALU result in the same cycle, then an ALU stream.
        s = idle_stim(); s.li = 1; s.ld = 5'd3; s.lt = 3'd4; step(s);
        s = idle_stim(); s.mv = 1; s.md = 32'hCAFE_0003; s.av = 1; s.ad = 5'd9;
        s.adat = 32'h0000_0009; s.ck = 5'd9;
        step(s);
        for (int i = 0; i < 6; i++) begin
            for (int t = 0; t < 4; t++) begin
                s = idle_stim(); s.av = 1; s.ad = 5'(10 + i); s.adat = 32'(100 + i); s.ck = 5'd9;
                step(s);
                if (m_acc_a) break;
            end
        end
        idle(2);

        // Hazard on a pending load, on an unrelated register, and on dest 0.
        s = idle_stim(); s.li = 1; s.ld = 5'd5; s.ck = 5'd5; step(s);
        s = idle_stim(); s.ck = 5'd5; step(s);
        s = idle_stim(); s.ck = 5'd6; step(s);
        s = idle_stim(); s.ck = 5'd5; s.mv = 1; s.md = 32'h5555_0005; s.ld = 5'd5; s.li = 1; step(s);
        s = idle_stim(); s.ck = 5'd5; step(s);
        s = idle_stim(); s.li = 1; s.ld = 5'd0; s.ck = 5'd0; step(s);
        s = idle_stim(); s.ck = 5'd0; step(s);
        s = idle_stim(); s.mv = 1; s.md = 32'h0000_00AA; step(s);
        idle(1);

        // Reset in the middle of a load, then a late memory response.
        s = idle_stim(); s.li = 1; s.ld = 5'd4; s.lt = 3'd4; step(s);
        idle(1);
        s = idle_stim(); s.rst_n = 1'b0; s.mv = 1; s.md = 32'h4444_4444; step(s);
        step(s);
        s = idle_stim(); s.mv = 1; s.md = 32'h4444_4444; s.ck = 5'd4; step(s);
        idle(2);

        // Randomised traffic. ALU offers are held until the model accepts them.
        s = idle_stim();
        for (int i = 0; i < 3000; i++) begin
            if (!s.av || m_acc_a) begin
                s.av   = ($urandom_range(0, 9) < 6);
                s.ad   = 5'($urandom_range(0, 31));
                s.adat = $urandom;
            end
            s.li = ($urandom_range(0, 9) < 3);
            s.ld = 5'($urandom_range(0, 31));
            s.lt = 3'($urandom_range(0, 7));
            s.lo = 2'($urandom_range(0, 3));
            s.mv = ($urandom_range(0, 9) < 4);
            s.md = $urandom;
            case ($urandom_range(0, 3))
                0:       s.ck = m_pdest;
                1:       s.ck = (m_alu_q.size() > 0) ? m_alu_q[0].dest : 5'd0;
                default: s.ck = 5'($urandom_range(0, 31));
            endcase
            step(s);
        end
        s = idle_stim(); s.mv = 1; s.md = 32'h0BAD_F00D; step(s);
        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
